// File: rtl/fetch_unit_pkg.sv
// Shared encodings, FSM states and default widths for the instruction-fetch stage.
package fetch_pkg;
    localparam int FETCH_PC_W          = 12;
    localparam int FETCH_INSTR_W       = 19;
    localparam int FETCH_STACK_DEPTH   = 8;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_JMP = 2'd1;
    localparam logic [1:0] PCSEL_RET = 2'd2;
    localparam logic [1:0] PCSEL_BR  = 2'd3;

    localparam logic [FETCH_INSTR_W-1:0] FETCH_NOP = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HALTED
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Control/status bundle between the decode-stage controller and the fetch unit.
interface fetch_unit_if #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 19
);
    logic               start;
    logic               halt;
    logic               hazard;
    logic               pcWriteCU;
    logic [1:0]         pcSel;
    logic               push;
    logic               pop;
    logic [PC_W-1:0]    jumpAddr;
    logic [7:0]         branchOff;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ifidInstr;
    logic [PC_W-1:0]    ifidPc;
    logic               stackErr;

    modport master (
        output start, halt, hazard, pcWriteCU, pcSel, push, pop, jumpAddr, branchOff,
        input  pc, ifidInstr, ifidPc, stackErr
    );

    modport slave (
        input  start, halt, hazard, pcWriteCU, pcSel, push, pop, jumpAddr, branchOff,
        output pc, ifidInstr, ifidPc, stackErr
    );
endinterface

// File: rtl/fetch_unit_return_stack.sv
// Return-address stack; FETCH_STACK_GUARD_EN adds overflow/underflow detection,
// otherwise the pointer wraps and old entries are overwritten.
module return_stack #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] top,
    output logic              err
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign rd_idx = wr_idx - 1'b1;

`ifdef FETCH_STACK_GUARD_EN
    // One extra pointer bit distinguishes full (sp==DEPTH) from empty.
    logic [IDX_W:0] sp;
    logic           full;
    logic           empty;
    logic           err_q;

    assign wr_idx = sp[IDX_W-1:0];
    assign full   = (sp == (IDX_W+1)'(DEPTH));
    assign empty  = (sp == '0);
    assign top    = empty ? '0 : mem[rd_idx];
    assign err    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else if (clear) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else if (push) begin
            if (full) err_q <= 1'b1;
            else      sp    <= sp + 1'b1;
        end else if (pop) begin
            if (empty) err_q <= 1'b1;
            else       sp    <= sp - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_idx] <= wdata;
    end
`else
    logic [IDX_W-1:0] sp;

    assign wr_idx = sp;
    assign top    = mem[rd_idx];
    assign err    = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     sp <= '0;
        else if (clear) sp <= '0;
        else if (push)  sp <= sp + 1'b1;
        else if (pop)   sp <= sp - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= wdata;
    end
`endif
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, return stack and IF/ID register.
// Optional stack guard enabled by defining FETCH_STACK_GUARD_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W        = FETCH_PC_W,
    parameter int INSTR_W     = FETCH_INSTR_W,
    parameter int STACK_DEPTH = FETCH_STACK_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.slave        bus,
    input  logic [INSTR_W-1:0] instrIn,
    output logic [PC_W-1:0]    instrAddr
);
    fetch_state_t state, state_nx;

    logic [PC_W-1:0]        pc_p0;
    logic [PC_W-1:0]        pc_nx;
    logic [INSTR_W-1:0]     ifid_instr_p1;
    logic [PC_W-1:0]        ifid_pc_p1;
    logic signed [PC_W-1:0] br_off;
    logic [PC_W-1:0]        stack_top;
    logic                   stack_err;
    logic                   advance;
    logic                   load;

    assign load    = (state == ST_LOAD);
    assign advance = (state == ST_RUN) && !bus.hazard;
    assign br_off  = {{(PC_W-8){bus.branchOff[7]}}, bus.branchOff};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (bus.start)  state_nx = ST_LOAD;
            ST_LOAD:   if (!bus.start) state_nx = ST_RUN;
            ST_RUN:    if (bus.halt)   state_nx = ST_HALTED;
            ST_HALTED: if (bus.start)  state_nx = ST_LOAD;
            default:                   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_nx = pc_p0 + 1'b1;
        case (bus.pcSel)
            PCSEL_JMP: pc_nx = bus.jumpAddr;
            PCSEL_RET: pc_nx = stack_top;
            PCSEL_BR:  pc_nx = ifid_pc_p1 + br_off;
            default:   pc_nx = pc_p0 + 1'b1;
        endcase
    end

    // ---- stage 0: program counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          pc_p0 <= '0;
        else if (load)                     pc_p0 <= '0;
        else if (advance && bus.pcWriteCU) pc_p0 <= pc_nx;
    end

    // ---- stage 1: IF/ID register; any redirect flushes in a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_instr_p1 <= INSTR_W'(FETCH_NOP);
            ifid_pc_p1    <= '0;
        end else if (advance) begin
            if (bus.pcSel == PCSEL_SEQ) begin
                ifid_instr_p1 <= instrIn;
                ifid_pc_p1    <= pc_p0;
            end else begin
                ifid_instr_p1 <= INSTR_W'(FETCH_NOP);
            end
        end
    end

    // Push wins over a simultaneous pop; the return target is read before the update.
    return_stack #(
        .DATA_W (PC_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst),
        .clear (load),
        .push  (advance && bus.push),
        .pop   (advance && bus.pop && !bus.push),
        .wdata (ifid_pc_p1 + 1'b1),
        .top   (stack_top),
        .err   (stack_err)
    );

    assign instrAddr     = pc_p0;
    assign bus.pc        = pc_p0;
    assign bus.ifidInstr = ifid_instr_p1;
    assign bus.ifidPc    = ifid_pc_p1;
    assign bus.stackErr  = stack_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit against a cycle-level reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [18:0] instrIn;
    logic [11:0] instrAddr;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit_if #(.PC_W(12), .INSTR_W(19)) bus ();

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .instrIn   (instrIn),
        .instrAddr (instrAddr)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mem_f(input logic [11:0] a);
        return {7'h2B, a ^ 12'h5A5};
    endfunction

    assign instrIn = mem_f(instrAddr);

    typedef struct {
        logic [11:0] pc;
        logic [11:0] ifpc;
        logic [18:0] ifi;
        int          sp;
        bit          err;
    } exp_t;

    exp_t sb[$];

    fetch_state_t m_state;
    logic [11:0]  m_pc, m_ifpc;
    logic [18:0]  m_ifi;
    int           m_sp;
    bit           m_err;
    logic [11:0]  m_stack [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE;
        m_pc    = '0;
        m_ifpc  = '0;
        m_ifi   = FETCH_NOP;
        m_sp    = 0;
        m_err   = 1'b0;
    endtask

    task automatic cyc(input bit st, input bit hl, input bit hz, input logic [1:0] sel,
                       input bit pu, input bit po, input logic [11:0] ja, input logic [7:0] bo);
        exp_t         e;
        logic [11:0]  npc, nifpc, top;
        logic [18:0]  nifi;
        int           nsp;
        bit           nerr;
        fetch_state_t nst;
        bus.start = st; bus.halt = hl; bus.hazard = hz; bus.pcWriteCU = 1'b1;
        bus.pcSel = sel; bus.push = pu; bus.pop = po; bus.jumpAddr = ja; bus.branchOff = bo;
        npc = m_pc; nifpc = m_ifpc; nifi = m_ifi; nsp = m_sp; nerr = m_err; nst = m_state;
        if (m_state == ST_LOAD) begin
            npc = '0; nsp = 0; nerr = 1'b0;
        end
        if (m_state == ST_RUN && !hz) begin
`ifdef FETCH_STACK_GUARD_EN
            top = (m_sp == 0) ? 12'h000 : m_stack[m_sp-1];
`else
            top = m_stack[(m_sp + 7) % 8];
`endif
            case (sel)
                2'd0: npc = m_pc + 12'd1;
                2'd1: npc = ja;
                2'd2: npc = top;
                default: npc = m_ifpc + {{4{bo[7]}}, bo};
            endcase
            if (sel == 2'd0) begin
                nifi = mem_f(m_pc); nifpc = m_pc;
            end else begin
                nifi = FETCH_NOP;
            end
            if (pu) begin
`ifdef FETCH_STACK_GUARD_EN
                if (m_sp == 8) nerr = 1'b1;
                else begin m_stack[m_sp] = m_ifpc + 12'd1; nsp = m_sp + 1; end
`else
                m_stack[m_sp] = m_ifpc + 12'd1; nsp = (m_sp + 1) % 8;
`endif
            end else if (po) begin
`ifdef FETCH_STACK_GUARD_EN
                if (m_sp == 0) nerr = 1'b1;
                else nsp = m_sp - 1;
`else
                nsp = (m_sp + 7) % 8;
`endif
            end
        end
        case (m_state)
            ST_IDLE:   if (st)  nst = ST_LOAD;
            ST_LOAD:   if (!st) nst = ST_RUN;
            ST_RUN:    if (hl)  nst = ST_HALTED;
            ST_HALTED: if (st)  nst = ST_LOAD;
            default:   nst = ST_IDLE;
        endcase
        m_state = nst; m_pc = npc; m_ifpc = nifpc; m_ifi = nifi; m_sp = nsp; m_err = nerr;
        e.pc = npc; e.ifpc = nifpc; e.ifi = nifi; e.sp = nsp; e.err = nerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc",        bus.pc,              e.pc);
        chk("instrAddr", instrAddr,           e.pc);
        chk("ifidPc",    bus.ifidPc,          e.ifpc);
        chk("ifidInstr", bus.ifidInstr,       e.ifi);
        chk("sp",        int'(dut.u_stack.sp), e.sp);
        chk("stackErr",  bus.stackErr,        e.err);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'd0, 0, 0, 12'h000, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_stack[i] = '0;
        bus.start = 0; bus.halt = 0; bus.hazard = 0; bus.pcWriteCU = 1; bus.pcSel = 0;
        bus.push = 0; bus.pop = 0; bus.jumpAddr = '0; bus.branchOff = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",     bus.pc,              12'h000);
        chk("rst_ifidPc", bus.ifidPc,          12'h000);
        chk("rst_ifidIn", bus.ifidInstr,       FETCH_NOP);
        chk("rst_err",    bus.stackErr,        1'b0);
        chk("rst_sp",     int'(dut.u_stack.sp), 0);
        rst = 1'b1;

        seq(2);
        chk("idle_pc", bus.pc, 12'h000);
        cyc(1, 0, 0, 2'd0, 0, 0, 12'h000, 8'h00);
        cyc(1, 0, 0, 2'd0, 0, 0, 12'h000, 8'h00);
        seq(6);
        chk("seq_pc",    bus.pc,        12'h005);
        chk("seq_ifpc",  bus.ifidPc,    12'h004);
        chk("seq_instr", bus.ifidInstr, mem_f(12'h004));

        cyc(0, 0, 0, 2'd1, 0, 0, 12'h0A0, 8'h00);
        chk("jmp_pc",    bus.pc,        12'h0A0);
        chk("jmp_bub",   bus.ifidInstr, FETCH_NOP);
        seq(1);
        chk("jmp_tgt",   bus.ifidInstr, mem_f(12'h0A0));

        cyc(0, 0, 0, 2'd1, 0, 0, 12'h00F, 8'h00);
        seq(2);
        chk("call_ifpc", bus.ifidPc, 12'h010);
        cyc(0, 0, 0, 2'd1, 1, 0, 12'h200, 8'h00);
        chk("call_sp",   int'(dut.u_stack.sp), 1);
        seq(2);
        cyc(0, 0, 0, 2'd2, 0, 1, 12'h000, 8'h00);
        chk("ret_pc",    bus.pc, 12'h011);
        chk("ret_sp",    int'(dut.u_stack.sp), 0);

        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2'd3, 1, 0, 12'h000, 8'h7F);
        chk("stall_pc",  bus.pc, 12'h011);
        chk("stall_sp",  int'(dut.u_stack.sp), 0);

        cyc(0, 0, 0, 2'd1, 0, 0, 12'h002, 8'h00);
        seq(1);
        cyc(0, 0, 0, 2'd3, 0, 0, 12'h000, 8'hFC);
        chk("br_wrap",   bus.pc, 12'hFFE);
        seq(2);
        chk("seq_wrap",  bus.pc, 12'h000);
        chk("wrap_ifpc", bus.ifidPc, 12'hFFF);

        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 2'd0, 1, 0, 12'h000, 8'h00);
`ifdef FETCH_STACK_GUARD_EN
        chk("ovf_err",   bus.stackErr, 1'b1);
        chk("ovf_sp",    int'(dut.u_stack.sp), 8);
`else
        chk("ovf_err",   bus.stackErr, 1'b0);
        chk("ovf_sp",    int'(dut.u_stack.sp), 1);
`endif
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 2'd0, 0, 1, 12'h000, 8'h00);
`ifdef FETCH_STACK_GUARD_EN
        chk("unf_err",   bus.stackErr, 1'b1);
        chk("unf_sp",    int'(dut.u_stack.sp), 0);
`else
        chk("unf_err",   bus.stackErr, 1'b0);
        chk("unf_sp",    int'(dut.u_stack.sp), 7);
`endif

        cyc(0, 1, 0, 2'd1, 0, 0, 12'h123, 8'h00);
        seq(2);
        chk("halt_pc",   bus.pc, 12'h123);
        cyc(1, 0, 0, 2'd0, 0, 0, 12'h000, 8'h00);
        cyc(0, 0, 0, 2'd0, 0, 0, 12'h000, 8'h00);
        chk("load_pc",   bus.pc, 12'h000);
        chk("load_err",  bus.stackErr, 1'b0);
        seq(3);
        chk("rerun_pc",  bus.pc, 12'h003);

        #2 rst = 1'b0;
        #1;
        chk("arst_pc",    bus.pc,        12'h000);
        chk("arst_instr", bus.ifidInstr, FETCH_NOP);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        seq(3);
        chk("post_rst_pc", bus.pc, 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
